// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl shared types: ALU opcodes, widths, FSM encoding.
package alu_issue_ctrl_pkg;

  localparam int ALU_OPW = 5;
  localparam int ALU_DW  = 32;

  localparam logic [ALU_OPW-1:0] OP_NOP = 5'h00;
  localparam logic [ALU_OPW-1:0] OP_ADD = 5'h01;
  localparam logic [ALU_OPW-1:0] OP_SUB = 5'h02;
  localparam logic [ALU_OPW-1:0] OP_AND = 5'h03;
  localparam logic [ALU_OPW-1:0] OP_OR  = 5'h04;
  localparam logic [ALU_OPW-1:0] OP_XOR = 5'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command/response handshake bundle for alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  import alu_issue_ctrl_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [ALU_OPW-1:0] cmd_opcode;
  logic [ALU_DW-1:0]  cmd_a;
  logic [ALU_DW-1:0]  cmd_b;
  logic [TAG_W-1:0]   cmd_tag;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [ALU_DW-1:0]  rsp_result;
  logic               rsp_overflow;
  logic               rsp_error;
  logic [TAG_W-1:0]   rsp_tag;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a,
    output cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result,
    input  rsp_overflow, rsp_error, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a,
    input  cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result,
    output rsp_overflow, rsp_error, rsp_tag
  );

endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// alu_cmd_fifo: in-order command buffer, power-of-2 depth.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push_ok)
                 - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer: FIFO -> ALU -> tagged response.
// Define ALU_TIMEOUT_EN to force an error after TIMEOUT_CYCLES.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int CMD_DEPTH      = 2,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_issue_ctrl_if.slave    bus,
  output logic               alu_enable,
  output logic [ALU_OPW-1:0] alu_opcode,
  output logic [ALU_DW-1:0]  alu_data_a,
  output logic [ALU_DW-1:0]  alu_data_b,
  input  logic [ALU_DW-1:0]  alu_result,
  input  logic               alu_overflow,
  input  logic               alu_error,
  input  logic               alu_done,
  output logic               busy
);

  localparam int FW = ALU_OPW + 2*ALU_DW + TAG_W;

  if (CMD_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("alu_issue_ctrl: bad parameters");
  end

  state_t             state;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               hs;
  logic               timeout;
  logic [FW-1:0]      head;
  logic [ALU_OPW-1:0] h_op;
  logic [ALU_DW-1:0]  h_a;
  logic [ALU_DW-1:0]  h_b;
  logic [TAG_W-1:0]   h_tag;
  logic [TAG_W-1:0]   tag_q;

  logic               rsp_valid_q;
  logic [ALU_DW-1:0]  rsp_result_q;
  logic               rsp_ovf_q;
  logic               rsp_err_q;
  logic [TAG_W-1:0]   rsp_tag_q;

  assign push = bus.cmd_valid && !full;
  assign hs   = (state == RESP) && bus.rsp_ready;
  assign pop  = !empty && ((state == IDLE) || hs);
  assign busy = (state != IDLE) || !empty;

  assign bus.cmd_ready    = !full;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_error    = rsp_err_q;
  assign bus.rsp_tag      = rsp_tag_q;

  assign {h_op, h_a, h_b, h_tag} = head;

  alu_cmd_fifo #(
    .W     (FW),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({bus.cmd_opcode, bus.cmd_a,
               bus.cmd_b, bus.cmd_tag}),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty)
  );

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign timeout = to_cnt == TW'(TIMEOUT_CYCLES - 1);

  // Counts EXEC cycles already spent on the current op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           to_cnt <= '0;
    else if (state != EXEC) to_cnt <= '0;
    else                    to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_opcode <= '0;
      alu_data_a <= '0;
      alu_data_b <= '0;
      tag_q      <= '0;
    end else if (pop) begin
      alu_opcode <= h_op;
      alu_data_a <= h_a;
      alu_data_b <= h_b;
      tag_q      <= h_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      alu_enable   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state      <= EXEC;
            alu_enable <= 1'b1;
          end
        end
        EXEC: begin
          if (alu_done || alu_error || timeout) begin
            state       <= RESP;
            alu_enable  <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_tag_q   <= tag_q;
            // Error beats done; done beats timeout.
            priority case (1'b1)
              alu_error: begin
                rsp_err_q    <= 1'b1;
                rsp_result_q <= '0;
                rsp_ovf_q    <= 1'b0;
              end
              alu_done: begin
                rsp_err_q <= 1'b0;
                if (alu_opcode == OP_NOP) begin
                  rsp_result_q <= '0;
                  rsp_ovf_q    <= 1'b0;
                end else begin
                  rsp_result_q <= alu_result;
                  rsp_ovf_q    <= alu_overflow;
                end
              end
              default: begin
                rsp_err_q    <= 1'b1;
                rsp_result_q <= '0;
                rsp_ovf_q    <= 1'b0;
              end
            endcase
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!empty) begin
              state      <= EXEC;
              alu_enable <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          alu_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a response-queue model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      res;
    logic             ovf;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_enable;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_data_a;
  logic [31:0] alu_data_b;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_error;
  logic        alu_done;
  logic        busy;
  bit          hang = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  rsp_t exp_q[$];
  int   hs_tag[$];
  int   hs_cyc[$];

  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_ctrl #(
    .CMD_DEPTH      (2),
    .TAG_W          (TAG_W),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .alu_enable   (alu_enable),
    .alu_opcode   (alu_opcode),
    .alu_data_a   (alu_data_a),
    .alu_data_b   (alu_data_b),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_error    (alu_error),
    .alu_done     (alu_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ALU stub; NOP result is garbage that must never surface.
  always_comb begin
    logic [31:0] s;
    s            = 32'h0;
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    alu_error    = 1'b0;
    alu_done     = 1'b0;
    if (alu_enable && !hang) begin
      alu_done = 1'b1;
      case (alu_opcode)
        OP_NOP: alu_result = 32'hDEAD_BEEF;
        OP_ADD: begin
          s = alu_data_a + alu_data_b;
          alu_result   = s;
          alu_overflow = (alu_data_a[31] == alu_data_b[31])
                       && (s[31] != alu_data_a[31]);
        end
        OP_SUB: begin
          s = alu_data_a - alu_data_b;
          alu_result   = s;
          alu_overflow = (alu_data_a[31] != alu_data_b[31])
                       && (s[31] != alu_data_a[31]);
        end
        OP_AND: alu_result = alu_data_a & alu_data_b;
        OP_OR:  alu_result = alu_data_a | alu_data_b;
        OP_XOR: alu_result = alu_data_a ^ alu_data_b;
        default: begin
          alu_done  = 1'b0;
          alu_error = 1'b1;
        end
      endcase
    end
  end

  function automatic rsp_t model(
    input logic [4:0]       op,
    input logic [31:0]      a,
    input logic [31:0]      b,
    input logic [TAG_W-1:0] tag,
    input bit               stall
  );
    longint sa;
    longint sb;
    longint s;
    rsp_t   r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r  = '0;
    r.tag = tag;
    if (stall) begin
      r.err = 1'b1;
      return r;
    end
    case (op)
      OP_NOP: r.res = 32'h0;
      OP_ADD: s = sa + sb;
      OP_SUB: s = sa - sb;
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      default: r.err = 1'b1;
    endcase
    if (op == OP_ADD || op == OP_SUB) begin
      r.res = s[31:0];
      r.ovf = s != longint'($signed(s[31:0]));
    end
    return r;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic rsp_t cur_rsp();
    rsp_t r;
    r.res = bus.rsp_result;
    r.ovf = bus.rsp_overflow;
    r.err = bus.rsp_error;
    r.tag = bus.rsp_tag;
    return r;
  endfunction

  // Per-cycle compare against the expected-response queue.
  initial begin
    rsp_t prev;
    rsp_t cur;
    rsp_t e;
    bit   prev_v;
    bit   prev_hs;
    prev   = '0;
    prev_v = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        prev_v = 1'b0;
        prev_hs = 1'b0;
      end else begin
        cur = cur_rsp();
        if (bus.cmd_valid && bus.cmd_ready)
          exp_q.push_back(model(bus.cmd_opcode,
            bus.cmd_a, bus.cmd_b, bus.cmd_tag, hang));
        chk("enable_vs_valid",
            64'(alu_enable && bus.rsp_valid), 64'd0);
        if (prev_v && !prev_hs) begin
          chk("rsp_hold", 64'(bus.rsp_valid), 64'd1);
          chk("rsp_stable", 64'(cur), 64'(prev));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_rsp", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_model", 64'(cur), 64'(e));
          end
          hs_tag.push_back(int'(bus.rsp_tag));
          hs_cyc.push_back(cyc);
        end
        prev    = cur;
        prev_v  = bus.rsp_valid;
        prev_hs = bus.rsp_valid && bus.rsp_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [4:0]       op,
    input logic [31:0]      a,
    input logic [31:0]      b,
    input logic [TAG_W-1:0] tag
  );
    int n;
    n = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_tag    = tag;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) chk("send_timeout", 64'd1, 64'd0);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 60) begin
      tick();
      n++;
    end
    chk(nm, 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus.rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy || bus.rsp_valid), 64'd0);
  endtask

  initial begin
    int acc;
    int n;
    int en_cnt;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.cmd_tag    = '0;
    bus.rsp_ready  = 1'b0;

    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_alu_en", 64'(alu_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_tag", 64'(bus.rsp_tag), 64'd0);
    chk("rst_opcode", 64'(alu_opcode), 64'd0);
    reset_n = 1'b1;
    tick();

    // ADD 7+5 with latency check.
    bus.rsp_ready = 1'b1;
    send(OP_ADD, 32'd7, 32'd5, 4'd3);
    chk("lat_n", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("lat_n1_valid", 64'(bus.rsp_valid), 64'd0);
    chk("lat_n1_exec", 64'(alu_enable), 64'd1);
    tick();
    chk("lat_n2_valid", 64'(bus.rsp_valid), 64'd1);
    chk("add_result", 64'(bus.rsp_result), 64'd12);
    chk("add_tag", 64'(bus.rsp_tag), 64'd3);
    chk("add_flags", 64'({bus.rsp_overflow,
        bus.rsp_error}), 64'd0);
    tick();
    chk("valid_drop", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b0;

    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd1);
    wait_rsp("ovf_wait");
    chk("ovf_result", 64'(bus.rsp_result), 64'h8000_0000);
    chk("ovf_flags", 64'({bus.rsp_overflow,
        bus.rsp_error}), 64'b10);
    drain();

    send(5'h1F, 32'h1234, 32'h5678, 4'd2);
    wait_rsp("err_wait");
    chk("err_flags", 64'({bus.rsp_overflow,
        bus.rsp_error}), 64'b01);
    chk("err_result", 64'(bus.rsp_result), 64'd0);
    drain();

    send(OP_NOP, 32'd1, 32'd2, 4'd9);
    wait_rsp("nop_wait");
    chk("nop_result", 64'(bus.rsp_result), 64'd0);
    chk("nop_tag", 64'(bus.rsp_tag), 64'd9);
    drain();

    bus.rsp_ready = 1'b1;
    send(OP_SUB, 32'h8000_0000, 32'd1, 4'd4);
    send(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5);
    send(OP_SUB, 32'd3, 32'd10, 4'd6);
    wait_idle();
    bus.rsp_ready = 1'b0;

    // Back-pressure: 2 queued + 1 in flight.
    hs_tag.delete();
    hs_cyc.delete();
    acc = 0;
    for (int t = 0; t < 4; t++) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = OP_ADD;
      bus.cmd_a      = 32'(t * 100);
      bus.cmd_b      = 32'(t);
      bus.cmd_tag    = TAG_W'(t);
      n = 0;
      while (!bus.cmd_ready && n < 10) begin
        tick();
        n++;
      end
      if (!bus.cmd_ready) break;
      tick();
      acc++;
    end
    chk("accepts", 64'(acc), 64'd3);
    chk("cmd_ready_full", 64'(bus.cmd_ready), 64'd0);
    chk("stall_tag", 64'(bus.rsp_tag), 64'd0);
    chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.cmd_valid = 1'b0;
    wait_idle();
    bus.rsp_ready = 1'b0;
    chk("order_cnt", 64'(hs_tag.size()), 64'd4);
    if (hs_tag.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk("order_tag", 64'(hs_tag[i]), 64'(i));
      for (int i = 1; i < 4; i++)
        chk("throughput",
            64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);
    end

`ifdef ALU_TIMEOUT_EN
    hang = 1'b1;
    send(OP_ADD, 32'd1, 32'd1, 4'd6);
    en_cnt = 0;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      if (alu_enable) en_cnt++;
      tick();
      n++;
    end
    chk("to_cycles", 64'(en_cnt), 64'd15);
    chk("to_error", 64'(bus.rsp_error), 64'd1);
    chk("to_result", 64'(bus.rsp_result), 64'd0);
    chk("to_tag", 64'(bus.rsp_tag), 64'd6);
    hang = 1'b0;
    drain();
    wait_idle();
`else
    en_cnt = 0;
`endif

    // Reset while stuck in EXEC.
    bus.rsp_ready = 1'b1;
    hang = 1'b1;
    send(OP_ADD, 32'd2, 32'd2, 4'd7);
    tick();
    chk("pre_rst_exec", 64'(alu_enable), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_en", 64'(alu_enable), 64'd0);
    chk("rst_async_vld", 64'(bus.rsp_valid), 64'd0);
    chk("rst_async_busy", 64'(busy), 64'd0);
    hang = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    send(OP_OR, 32'h0F00, 32'h00F0, 4'd8);
    wait_rsp("post_rst_wait");
    chk("post_rst_or", 64'(bus.rsp_result), 64'h0FF0);
    wait_idle();
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
